// File: rtl/fifo_tx_gen.sv
// Parametrised transmit FIFO between the host and the UART transmitter.
// Words are buffered until a drain begins, then released one per next_frame request.
module fifo_tx_gen #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int AF_LEVEL    = 12,
    parameter int AUTO_START  = 0,
    parameter int START_LEVEL = 8
) (
    input  logic                     clk_fifo_tx,
    input  logic                     rst_fifo_tx_n,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     wr_en,
    input  logic                     start_tx,
    input  logic                     next_frame,
    input  logic                     flush,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic                     fifo_tx_status,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                overflow_q, overflow_d;

    logic pop, wr_accept, wr_drop, start_hit;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CNT_W'(AF_LEVEL));

    // Flush beats everything, so it also masks the pop and the write.
    assign pop       = (state_q == DRAIN) && next_frame && !empty && !flush;
    assign wr_accept = wr_en && (!full || pop) && !flush;
    assign wr_drop   = wr_en && full && !pop && !flush;
    assign start_hit = (start_tx && !empty) ||
                       ((AUTO_START != 0) && (count_q >= CNT_W'(START_LEVEL)));

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = pop;
        overflow_d   = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop) begin
                data_out_d = mem_q[rd_ptr_q];
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            end
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (wr_accept && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !wr_accept) begin
                count_d = count_q - CNT_W'(1);
            end
            if (wr_drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control registers and the IDLE/DRAIN state machine.
    always_ff @(posedge clk_fifo_tx or negedge rst_fifo_tx_n) begin
        if (!rst_fifo_tx_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            if (flush) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE:    if (start_hit) state_q <= DRAIN;
                    DRAIN:   if (pop && (count_q == CNT_W'(1)) && !wr_accept) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Storage array is not reset; contents are meaningless once pointers clear.
    always_ff @(posedge clk_fifo_tx) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out       = data_out_q;
    assign data_valid     = data_valid_q;
    assign fifo_tx_status = (state_q == DRAIN);
    assign count          = count_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_fifo_tx_gen.sv
// Directed testbench for fifo_tx_gen: default instance plus an auto-start instance.
module tb_fifo_tx_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = '0;
    logic       wr_en = 0, start_tx = 0, next_frame = 0, flush = 0;
    logic [7:0] data_out;
    logic       data_valid, status, full, empty, almost_full, overflow;
    logic [4:0] count;

    logic [7:0] a_data_in = '0;
    logic       a_wr_en = 0;
    logic [7:0] a_data_out;
    logic       a_data_valid, a_status, a_full, a_empty, a_almost_full, a_overflow;
    logic [4:0] a_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_tx_gen dut (
        .clk_fifo_tx(clk), .rst_fifo_tx_n(rst_n), .data_in(data_in), .wr_en(wr_en),
        .start_tx(start_tx), .next_frame(next_frame), .flush(flush),
        .data_out(data_out), .data_valid(data_valid), .fifo_tx_status(status),
        .full(full), .empty(empty), .almost_full(almost_full), .count(count),
        .overflow(overflow)
    );

    fifo_tx_gen #(.AUTO_START(1), .START_LEVEL(8)) dut_auto (
        .clk_fifo_tx(clk), .rst_fifo_tx_n(rst_n), .data_in(a_data_in), .wr_en(a_wr_en),
        .start_tx(1'b0), .next_frame(1'b0), .flush(1'b0),
        .data_out(a_data_out), .data_valid(a_data_valid), .fifo_tx_status(a_status),
        .full(a_full), .empty(a_empty), .almost_full(a_almost_full), .count(a_count),
        .overflow(a_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #7;
        checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_out got %0h exp 00", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_valid got %0b exp 0", data_valid); end
        checks++; if (status !== 1'b0) begin errors++; $display("[TB] FAIL reset_status got %0b exp 0", status); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got e%0b f%0b af%0b exp e1 f0 af0", empty, full, almost_full); end
        checks++; if (count !== 5'd0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_count_ovf got %0d/%0b exp 0/0", count, overflow); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_auto_start();
        for (int i = 0; i < 7; i++) begin
            a_data_in = 8'hA0 + 8'(i); a_wr_en = 1'b1;
            tick();
        end
        a_wr_en = 1'b0;
        tick(); tick();
        checks++; if (a_count !== 5'd7) begin errors++; $display("[TB] FAIL auto_count7 got %0d exp 7", a_count); end
        checks++; if (a_status !== 1'b0) begin errors++; $display("[TB] FAIL auto_below_level got %0b exp 0", a_status); end
        a_data_in = 8'hA7; a_wr_en = 1'b1;
        tick();
        a_wr_en = 1'b0;
        tick();
        checks++; if (a_status !== 1'b1) begin errors++; $display("[TB] FAIL auto_at_level got %0b exp 1", a_status); end
    endtask

    task automatic test_basic_drain();
        for (int i = 0; i < 5; i++) begin
            data_in = 8'h01 + 8'(i); wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        checks++; if (count !== 5'd5) begin errors++; $display("[TB] FAIL basic_count got %0d exp 5", count); end
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        checks++; if (status !== 1'b1) begin errors++; $display("[TB] FAIL basic_status got %0b exp 1", status); end
        next_frame = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i < 5) begin
                checks++; if (data_valid !== 1'b1 || data_out !== 8'h01 + 8'(i)) begin errors++; $display("[TB] FAIL basic_pop%0d got v%0b %0h exp v1 %0h", i, data_valid, data_out, 8'h01 + 8'(i)); end
            end else begin
                checks++; if (data_valid !== 1'b0 || data_out !== 8'h05) begin errors++; $display("[TB] FAIL basic_extra got v%0b %0h exp v0 05", data_valid, data_out); end
            end
        end
        next_frame = 1'b0;
        checks++; if (status !== 1'b0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL basic_end got s%0b e%0b exp s0 e1", status, empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) begin
            data_in = 8'h10 + 8'(i); wr_en = 1'b1;
            tick();
            if (i == 10) begin
                checks++; if (almost_full !== 1'b0) begin errors++; $display("[TB] FAIL af_at11 got %0b exp 0", almost_full); end
            end
            if (i == 11) begin
                checks++; if (almost_full !== 1'b1) begin errors++; $display("[TB] FAIL af_at12 got %0b exp 1", almost_full); end
            end
            if (i == 15) begin
                checks++; if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL full16 got f%0b c%0d o%0b exp f1 c16 o0", full, count, overflow); end
            end
        end
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1 || count !== 5'd16) begin errors++; $display("[TB] FAIL ovf17 got o%0b c%0d exp o1 c16", overflow, count); end
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        next_frame = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (i < 16) begin
                checks++; if (data_valid !== 1'b1 || data_out !== 8'h10 + 8'(i)) begin errors++; $display("[TB] FAIL ovf_pop%0d got v%0b %0h exp v1 %0h", i, data_valid, data_out, 8'h10 + 8'(i)); end
            end else begin
                checks++; if (data_valid !== 1'b0 || data_out !== 8'h1F) begin errors++; $display("[TB] FAIL ovf_no20 got v%0b %0h exp v0 1f", data_valid, data_out); end
            end
        end
        next_frame = 1'b0;
        checks++; if (overflow !== 1'b1 || status !== 1'b0) begin errors++; $display("[TB] FAIL ovf_sticky got o%0b s%0b exp o1 s0", overflow, status); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_flush got %0b exp 0", overflow); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            data_in = 8'h30 + 8'(i); wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'h40 + 8'(i); wr_en = 1'b1; next_frame = 1'b1;
            tick();
            checks++; if (data_valid !== 1'b1 || data_out !== 8'h30 + 8'(i)) begin errors++; $display("[TB] FAIL b2b_pop%0d got v%0b %0h exp v1 %0h", i, data_valid, data_out, 8'h30 + 8'(i)); end
            checks++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL b2b_flags%0d got c%0d f%0b o%0b exp c16 f1 o0", i, count, full, overflow); end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++; if (data_valid !== 1'b1 || data_out !== 8'h34 + 8'(i)) begin errors++; $display("[TB] FAIL wrap_pop%0d got v%0b %0h exp v1 %0h", i, data_valid, data_out, 8'h34 + 8'(i)); end
        end
        next_frame = 1'b0;
        checks++; if (empty !== 1'b1 || status !== 1'b0) begin errors++; $display("[TB] FAIL wrap_end got e%0b s%0b exp e1 s0", empty, status); end
    endtask

    task automatic test_count_one();
        data_in = 8'h50; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        data_in = 8'h51; wr_en = 1'b1; next_frame = 1'b1;
        tick();
        wr_en = 1'b0;
        checks++; if (data_out !== 8'h50 || count !== 5'd1 || status !== 1'b1) begin errors++; $display("[TB] FAIL one_simul got %0h c%0d s%0b exp 50 c1 s1", data_out, count, status); end
        tick();
        next_frame = 1'b0;
        checks++; if (data_out !== 8'h51 || count !== 5'd0 || status !== 1'b0) begin errors++; $display("[TB] FAIL one_last got %0h c%0d s%0b exp 51 c0 s0", data_out, count, status); end
        data_in = 8'h60; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; next_frame = 1'b1;
        tick();
        next_frame = 1'b0;
        checks++; if (data_valid !== 1'b0 || data_out !== 8'h51 || count !== 5'd1) begin errors++; $display("[TB] FAIL idle_nf got v%0b %0h c%0d exp v0 51 c1", data_valid, data_out, count); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            data_in = 8'h70 + 8'(i); wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0; start_tx = 1'b1;
        tick();
        start_tx = 1'b0; next_frame = 1'b1;
        tick(); tick();
        next_frame = 1'b0;
        checks++; if (count !== 5'd3 || data_out !== 8'h71) begin errors++; $display("[TB] FAIL flush_pre got c%0d %0h exp c3 71", count, data_out); end
        flush = 1'b1; wr_en = 1'b1; data_in = 8'h99;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        checks++; if (count !== 5'd0 || empty !== 1'b1 || status !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL flush_state got c%0d e%0b s%0b o%0b exp c0 e1 s0 o0", count, empty, status, overflow); end
        checks++; if (data_out !== 8'h71 || data_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_dout got %0h v%0b exp 71 v0", data_out, data_valid); end
        tick();
        checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL flush_wr_drop got c%0d exp c0", count); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            data_in = 8'h80 + 8'(i); wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0; start_tx = 1'b1;
        tick();
        start_tx = 1'b0; next_frame = 1'b1;
        tick();
        next_frame = 1'b0;
        checks++; if (data_out !== 8'h80 || status !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre got %0h s%0b exp 80 s1", data_out, status); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (data_out !== 8'h00 || data_valid !== 1'b0 || status !== 1'b0 || count !== 5'd0) begin errors++; $display("[TB] FAIL arst_mid got %0h v%0b s%0b c%0d exp 00 v0 s0 c0", data_out, data_valid, status, count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL arst_flags got e%0b f%0b o%0b exp e1 f0 o0", empty, full, overflow); end
        #2;
        rst_n = 1'b1;
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        tick();
        checks++; if (status !== 1'b0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL arst_start_empty got s%0b e%0b exp s0 e1", status, empty); end
    endtask

    initial begin
        test_reset();
        test_auto_start();
        test_basic_drain();
        test_overflow();
        test_back_to_back();
        test_count_one();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
